// File: rtl/ps2_mouse_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_pkg
//  Purpose  : Shared types and constants for the PS/2 mouse tracker: packet
//             decoder state encoding, header bit positions, packet length.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mouse_pkg;

   // Packet assembly states; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      SKIP = 2'd0,
      HDR  = 2'd1,
      DX   = 2'd2,
      DY   = 2'd3
   } state_t;

   // Bit positions inside the PS/2 header byte.
   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;
   localparam int SYNC  = 3;
   localparam int XS    = 4;
   localparam int YS    = 5;
   localparam int XO    = 6;
   localparam int YO    = 7;

   // Bytes per standard PS/2 movement packet.
   localparam int PKT_LEN = 3;

endpackage
`default_nettype wire

// File: rtl/ps2_mouse_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_tracker_if
//  Purpose  : Bundles the byte-strobe input side and the cursor output side
//             of the mouse tracker.
//  Ports    : master - drives recenter/byte_valid/byte_data, reads results
//             slave  - the tracker: reads bytes, drives x_pos/y_pos/buttons,
//                      packet_valid and sync_error
//  Revision : 1.0 - initial release
// ============================================================================
interface ps2_mouse_tracker_if #(
   parameter int X_W = 10,
   parameter int Y_W = 9
);
   logic           recenter;
   logic           byte_valid;
   logic [7:0]     byte_data;
   logic [X_W-1:0] x_pos;
   logic [Y_W-1:0] y_pos;
   logic [2:0]     buttons;
   logic           packet_valid;
   logic           sync_error;

   modport master (
      output recenter, byte_valid, byte_data,
      input  x_pos, y_pos, buttons, packet_valid, sync_error
   );

   modport slave (
      input  recenter, byte_valid, byte_data,
      output x_pos, y_pos, buttons, packet_valid, sync_error
   );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_tracker_axis_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_axis_clamp
//  Purpose  : Signed add or subtract of a 9-bit delta to an unsigned axis
//             position, clamped to 0..LIMIT. Purely combinational.
//  Ports    : pos         - current position (unsigned)
//             delta       - 9-bit two's complement movement
//             subtract    - 1: pos - delta, 0: pos + delta
//             pos_clamped - resulting clamped position
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_axis_clamp #(
   parameter int POS_W = 10,
   parameter int AW    = 12,
   parameter int LIMIT = 319
) (
   input  logic [POS_W-1:0] pos,
   input  logic signed [8:0] delta,
   input  logic             subtract,
   output logic [POS_W-1:0] pos_clamped
);

   localparam logic signed [AW-1:0] c_limit = AW'(LIMIT);

   logic signed [AW-1:0] w_pos_ext;
   logic signed [AW-1:0] w_delta_ext;
   logic signed [AW-1:0] w_sum;

   // Position is zero-extended, delta sign-extended, so the sum never wraps.
   assign w_pos_ext   = signed'({{(AW-POS_W){1'b0}}, pos});
   assign w_delta_ext = signed'({{(AW-9){delta[8]}}, delta});
   assign w_sum       = subtract ? (w_pos_ext - w_delta_ext)
                                 : (w_pos_ext + w_delta_ext);

   always_comb begin
      pos_clamped = w_sum[POS_W-1:0];
      if (w_sum[AW-1]) begin
         pos_clamped = '0;
      end else if (w_sum > c_limit) begin
         pos_clamped = POS_W'(LIMIT);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_tracker
//  Purpose  : Assembles 3-byte PS/2 mouse packets from one-cycle byte strobes
//             (with sync check and idle resync) and integrates the deltas
//             into a clamped absolute cursor position plus button state.
//  Ports    : clk    - system clock
//             resetn - asynchronous active-low reset
//             bus    - slave side: recenter, byte_valid, byte_data in;
//                      x_pos, y_pos, buttons, packet_valid, sync_error out
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_tracker
   import mouse_pkg::*;
#(
   parameter int SCREEN_W    = 320,
   parameter int SCREEN_H    = 240,
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int SKIP_BYTES  = 2,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic               clk,
   input  logic               resetn,
   ps2_mouse_tracker_if.slave bus
);

   localparam int c_aw     = ((X_W > Y_W) ? X_W : Y_W) + 2;
   localparam int c_skip_w = (SKIP_BYTES > 1) ? $clog2(SKIP_BYTES) : 1;
   localparam int c_idle_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [X_W-1:0]      c_x_centre  = X_W'(SCREEN_W / 2);
   localparam logic [Y_W-1:0]      c_y_centre  = Y_W'(SCREEN_H / 2);
   localparam logic [c_skip_w-1:0] c_skip_last = c_skip_w'((SKIP_BYTES > 0) ? SKIP_BYTES - 1 : 0);
   localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam state_t              c_start     = (SKIP_BYTES == 0) ? HDR : SKIP;

   state_t r_state;
   state_t w_state_next;

   logic [c_skip_w-1:0]      r_skip;
   logic [c_idle_w-1:0]      r_idle;
   // [0] = header byte, [1] = dx byte; the dy byte is consumed on arrival.
   logic [PKT_LEN-2:0][7:0]  r_pkt;

   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic [2:0]     r_buttons;
   logic           r_packet_valid;
   logic           r_sync_error;

   logic           w_latch_hdr;
   logic           w_latch_dx;
   logic           w_commit;
   logic           w_bad_hdr;
   logic           w_timeout;
   logic           w_idle_done;
   logic           w_in_data;

   logic signed [8:0] w_dx;
   logic signed [8:0] w_dy;
   logic [X_W-1:0]    w_x_new;
   logic [Y_W-1:0]    w_y_new;

   // The stored sync bit is always 1 by construction and carries no data.
   logic w_unused_sync;
   assign w_unused_sync = r_pkt[0][SYNC];

   assign w_in_data   = (r_state == DX) || (r_state == DY);
   assign w_idle_done = (r_idle == c_idle_last);

   // ------------------------------------------------------------------
   // Packet FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= c_start;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_latch_hdr  = 1'b0;
      w_latch_dx   = 1'b0;
      w_commit     = 1'b0;
      w_bad_hdr    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         SKIP: begin
            if (bus.byte_valid && (r_skip == c_skip_last)) begin
               w_state_next = HDR;
            end
         end
         HDR: begin
            if (bus.byte_valid) begin
               if (bus.byte_data[SYNC]) begin
                  w_latch_hdr  = 1'b1;
                  w_state_next = DX;
               end else begin
                  w_bad_hdr = 1'b1;
               end
            end
         end
         DX: begin
            // A strobe on the expiry cycle takes priority over the timeout.
            if (bus.byte_valid) begin
               w_latch_dx   = 1'b1;
               w_state_next = DY;
            end else if (w_idle_done) begin
               w_timeout    = 1'b1;
               w_state_next = HDR;
            end
         end
         DY: begin
            if (bus.byte_valid) begin
               w_commit     = 1'b1;
               w_state_next = HDR;
            end else if (w_idle_done) begin
               w_timeout    = 1'b1;
               w_state_next = HDR;
            end
         end
         default: begin
            w_state_next = c_start;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Skip and idle counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_skip <= '0;
         r_idle <= '0;
      end else begin
         if ((r_state == SKIP) && bus.byte_valid) begin
            r_skip <= (r_skip == c_skip_last) ? '0 : r_skip + 1'b1;
         end
         if (w_in_data && !bus.byte_valid && !w_timeout) begin
            r_idle <= r_idle + 1'b1;
         end else begin
            r_idle <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Delta decode and position update
   // ------------------------------------------------------------------
   assign w_dx = r_pkt[0][XO] ? 9'sd0 : signed'({r_pkt[0][XS], r_pkt[1]});
   assign w_dy = r_pkt[0][YO] ? 9'sd0 : signed'({r_pkt[0][YS], bus.byte_data});

   mouse_axis_clamp #(
      .POS_W (X_W),
      .AW    (c_aw),
      .LIMIT (SCREEN_W - 1)
   ) u_clamp_x (
      .pos         (r_x),
      .delta       (w_dx),
      .subtract    (1'b0),
      .pos_clamped (w_x_new)
   );

   // Mouse +y points up while screen +y points down, hence subtract.
   mouse_axis_clamp #(
      .POS_W (Y_W),
      .AW    (c_aw),
      .LIMIT (SCREEN_H - 1)
   ) u_clamp_y (
      .pos         (r_y),
      .delta       (w_dy),
      .subtract    (1'b1),
      .pos_clamped (w_y_new)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pkt          <= '0;
         r_x            <= c_x_centre;
         r_y            <= c_y_centre;
         r_buttons      <= '0;
         r_packet_valid <= 1'b0;
         r_sync_error   <= 1'b0;
      end else begin
         r_packet_valid <= w_commit;
         r_sync_error   <= w_bad_hdr | w_timeout;
         if (w_latch_hdr) begin
            r_pkt[0] <= bus.byte_data;
         end
         if (w_latch_dx) begin
            r_pkt[1] <= bus.byte_data;
         end
         if (w_commit) begin
            r_buttons <= {r_pkt[0][BTN_M], r_pkt[0][BTN_R], r_pkt[0][BTN_L]};
         end
         // Recenter overrides a same-cycle commit for position only.
         if (bus.recenter) begin
            r_x <= c_x_centre;
            r_y <= c_y_centre;
         end else if (w_commit) begin
            r_x <= w_x_new;
            r_y <= w_y_new;
         end
      end
   end

   assign bus.x_pos        = r_x;
   assign bus.y_pos        = r_y;
   assign bus.buttons      = r_buttons;
   assign bus.packet_valid = r_packet_valid;
   assign bus.sync_error   = r_sync_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_tracker
//  Purpose  : Directed self-checking bench for ps2_mouse_tracker with
//             hand-computed expected cursor, button and pulse values.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_tracker;

   localparam int TB_TIMEOUT = 64;

   logic clk;
   logic resetn;

   int n_checks;
   int n_pass;
   int n_pv;
   int n_se;
   int last_pv;
   int after_pv;
   int last_se;
   int se_before;
   int pv_before;

   ps2_mouse_tracker_if #(.X_W(10), .Y_W(9)) bus ();

   ps2_mouse_tracker #(
      .SCREEN_W    (320),
      .SCREEN_H    (240),
      .X_W         (10),
      .Y_W         (9),
      .SKIP_BYTES  (2),
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (bus.packet_valid) n_pv++;
      if (bus.sync_error)   n_se++;
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle strobe, then two idle cycles; samples pulses the cycle after.
   task automatic send_byte(input logic [7:0] b, input logic rc);
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      bus.recenter   = rc;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.recenter   = 1'b0;
      last_pv = int'(bus.packet_valid);
      last_se = int'(bus.sync_error);
      @(negedge clk);
      after_pv = int'(bus.packet_valid);
   endtask

   task automatic send_pkt(input logic [7:0] h, input logic [7:0] x, input logic [7:0] y);
      send_byte(h, 1'b0);
      send_byte(x, 1'b0);
      send_byte(y, 1'b0);
   endtask

   task automatic check_pos(input string tag, input int ex, input int ey, input int eb);
      check_val({tag, "_x"}, int'(bus.x_pos), ex);
      check_val({tag, "_y"}, int'(bus.y_pos), ey);
      check_val({tag, "_btn"}, int'(bus.buttons), eb);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; n_pv = 0; n_se = 0;
      last_pv = 0; after_pv = 0; last_se = 0;
      bus.recenter   = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      resetn = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check_pos("reset", 160, 120, 0);
      check_val("reset_pv", int'(bus.packet_valid), 0);
      check_val("reset_se", int'(bus.sync_error), 0);
      resetn = 1'b1;

      // Two init bytes are swallowed (0xFA would pass as a header)
      send_byte(8'hFA, 1'b0);
      send_byte(8'hAA, 1'b0);
      check_val("skip_pv", n_pv, 0);
      check_val("skip_se", n_se, 0);

      // +10, +5 -> x 170, y 115
      send_pkt(8'h08, 8'h0A, 8'h05);
      check_pos("pkt1", 170, 115, 0);
      check_val("pkt1_pv", last_pv, 1);
      check_val("pkt1_pv_width", after_pv, 0);
      check_val("pkt1_pv_count", n_pv, 1);

      // Recenter pulse alone
      @(negedge clk); bus.recenter = 1'b1;
      @(negedge clk); bus.recenter = 1'b0;
      @(negedge clk);
      check_pos("recenter", 160, 120, 0);

      // dx = -256 from 160 clamps to 0, left button
      send_pkt(8'h19, 8'h00, 8'h00);
      check_pos("clamp_lo_x", 0, 120, 1);

      // dx = +255 -> 255 (inside range)
      send_pkt(8'h08, 8'hFF, 8'h00);
      check_pos("dx255", 255, 120, 0);

      // Bad header: sync_error, no state advance
      pv_before = n_pv;
      send_byte(8'h00, 1'b0);
      check_val("bad_hdr_se", last_se, 1);
      check_val("bad_hdr_se_count", n_se, 1);
      send_pkt(8'h08, 8'h01, 8'h01);
      check_pos("after_bad", 256, 119, 0);
      check_val("after_bad_pv", n_pv, pv_before + 1);

      // X overflow: dx ignored, dy = 2 upward
      send_pkt(8'h48, 8'h7F, 8'h02);
      check_pos("xovf", 256, 117, 0);

      // Timeout after header + dx
      se_before = n_se;
      pv_before = n_pv;
      send_byte(8'h08, 1'b0);
      send_byte(8'h05, 1'b0);
      repeat (TB_TIMEOUT - 14) @(negedge clk);
      check_val("timeout_not_early", n_se, se_before);
      repeat (30) @(negedge clk);
      check_val("timeout_se", n_se, se_before + 1);
      check_val("timeout_pv", n_pv, pv_before);
      check_pos("timeout_hold", 256, 117, 0);

      // Next packet decodes: dx +3, dy +254 clamps y to 0, right button
      send_pkt(8'h0A, 8'h03, 8'hFE);
      check_pos("clamp_lo_y", 259, 0, 2);

      // dy = -256 moves y down, clamps to 239
      send_pkt(8'h28, 8'h00, 8'h00);
      check_pos("clamp_hi_y", 259, 239, 0);

      // x upper clamp: 259 + 255 -> 319
      send_pkt(8'h08, 8'hFF, 8'h00);
      check_pos("clamp_hi_x", 319, 239, 0);

      // Recenter coincident with DY commit
      send_byte(8'h0C, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h10, 1'b1);
      check_pos("rc_commit", 160, 120, 4);
      check_val("rc_commit_pv", last_pv, 1);

      // Move away from centre, then reset mid-packet
      send_pkt(8'h0B, 8'h05, 8'h00);
      check_pos("pre_reset", 165, 120, 3);
      send_byte(8'h09, 1'b0);
      send_byte(8'h20, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      check_pos("async_reset", 160, 120, 0);
      check_val("async_reset_pv", int'(bus.packet_valid), 0);
      @(negedge clk);
      resetn = 1'b1;

      // SKIP restarts: two bytes discarded, then packet applies
      pv_before = n_pv;
      send_byte(8'hFA, 1'b0);
      send_byte(8'hAA, 1'b0);
      check_val("reskip_pv", n_pv, pv_before);
      send_pkt(8'h08, 8'h02, 8'h00);
      check_pos("post_reset", 162, 120, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
